// File: rtl/router_pkg.sv
// Shared constants and types for the 5-port mesh router.
// Port indices double as bit positions in every per-port vector.
package router_pkg;
    localparam int NUM_PORTS = 5;
    localparam int CREDIT_W  = 3;
    localparam int IDX_W     = 3;

    localparam int P_NORTH = 4;
    localparam int P_EAST  = 3;
    localparam int P_WEST  = 2;
    localparam int P_SOUTH = 1;
    localparam int P_LOCAL = 0;

    typedef enum logic {
        A_IDLE   = 1'b0,
        A_LOCKED = 1'b1
    } alloc_state_t;
endpackage

// File: rtl/rr_arbiter_5.sv
// Combinational 5-way round-robin arbiter: the search starts at the port just
// after ptr and wraps, so the previous winner gets the lowest priority.
module rr_arbiter_5
    import router_pkg::*;
(
    input  logic [4:0]       req,
    input  logic [IDX_W-1:0] ptr,
    output logic [4:0]       gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    logic [3:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 1; k <= 5; k++) begin
            // ptr never exceeds 4, so a single subtract is enough to wrap
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'd5)
                pos = pos - 4'd5;
            if (!valid && req[pos[2:0]]) begin
                valid          = 1'b1;
                gnt[pos[2:0]]  = 1'b1;
                idx            = pos[2:0];
            end
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin for head flits, a lock
// held from head to tail, and every transfer gated on downstream credit.
module switch_allocator
    import router_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS-1:0]          req_head_i,
    input  logic [NUM_PORTS-1:0]          req_tail_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_dir_i,
    input  logic [NUM_PORTS*CREDIT_W-1:0] credit_all_i,
    output logic [NUM_PORTS*IDX_W-1:0]    sel_o,
    output logic [NUM_PORTS-1:0]          sel_valid_o,
    output logic [NUM_PORTS-1:0]          send_data_o,
    output logic [NUM_PORTS-1:0]          counter_minus_o,
    output logic [NUM_PORTS-1:0]          locked_o,
    output logic                          proto_err_o
);
    logic [NUM_PORTS-1:0] dir       [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_req   [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_gnt   [NUM_PORTS];
    logic [IDX_W-1:0]     arb_idx   [NUM_PORTS];
    logic [IDX_W-1:0]     src       [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_valid, credit_ok, xfer, src_tail;
    logic [NUM_PORTS-1:0] dir_onehot, owns_any, err_vec, head_pop;

    alloc_state_t     state_reg [NUM_PORTS];
    alloc_state_t     state_next[NUM_PORTS];
    logic [IDX_W-1:0] owner_reg [NUM_PORTS];
    logic [IDX_W-1:0] owner_next[NUM_PORTS];
    logic [IDX_W-1:0] ptr_reg   [NUM_PORTS];
    logic [IDX_W-1:0] ptr_next  [NUM_PORTS];
    logic             proto_err_reg;

    always_comb begin
        owns_any = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            if (state_reg[o] == A_LOCKED)
                owns_any[owner_reg[o]] = 1'b1;
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign dir[gi]        = req_dir_i[gi*NUM_PORTS +: NUM_PORTS];
            assign dir_onehot[gi] = (dir[gi] != '0) && ((dir[gi] & (dir[gi] - 1'b1)) == '0);
            assign credit_ok[gi]  = credit_all_i[gi*CREDIT_W +: CREDIT_W] != '0;
            assign err_vec[gi]    = req_valid_i[gi] &
                                    (req_head_i[gi] ? (~dir_onehot[gi] | owns_any[gi])
                                                    : ~owns_any[gi]);

            // Only well-formed heads from free inputs may compete for output gi
            for (gj = 0; gj < NUM_PORTS; gj++) begin : g_req
                assign arb_req[gi][gj] = req_valid_i[gj] & req_head_i[gj] & dir[gj][gi] &
                                         dir_onehot[gj] & ~owns_any[gj];
            end

            rr_arbiter_5 u_arb (
                .req   (arb_req[gi]),
                .ptr   (ptr_reg[gi]),
                .gnt   (arb_gnt[gi]),
                .idx   (arb_idx[gi]),
                .valid (arb_valid[gi])
            );

            // A head from the owner is a protocol error, so the locked path takes body/tail only
            assign src[gi]      = (state_reg[gi] == A_LOCKED) ? owner_reg[gi] : arb_idx[gi];
            assign xfer[gi]     = ~rst & credit_ok[gi] &
                                  ((state_reg[gi] == A_LOCKED)
                                      ? (req_valid_i[owner_reg[gi]] & ~req_head_i[owner_reg[gi]])
                                      : arb_valid[gi]);
            assign src_tail[gi] = req_tail_i[src[gi]];

            assign sel_o[gi*IDX_W +: IDX_W] = xfer[gi] ? src[gi] : '0;
            assign sel_valid_o[gi]          = xfer[gi];
            assign counter_minus_o[gi]      = xfer[gi];
            assign locked_o[gi]             = (state_reg[gi] == A_LOCKED);
            assign head_pop[gi]             = xfer[gi] & (state_reg[gi] == A_IDLE) & (|arb_gnt[gi]);
        end
    endgenerate

    always_comb begin
        send_data_o = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            if (xfer[o])
                send_data_o[src[o]] = 1'b1;
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_next[o] = state_reg[o];
            owner_next[o] = owner_reg[o];
            ptr_next[o]   = ptr_reg[o];
            case (state_reg[o])
                A_IDLE: begin
                    if (head_pop[o]) begin
                        ptr_next[o] = src[o];
                        if (!src_tail[o]) begin
                            state_next[o] = A_LOCKED;
                            owner_next[o] = src[o];
                        end
                    end
                end
                A_LOCKED: begin
                    if (xfer[o] && src_tail[o])
                        state_next[o] = A_IDLE;
                end
                default: state_next[o] = A_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_reg[o] <= A_IDLE;
                owner_reg[o] <= '0;
                ptr_reg[o]   <= '0;
            end
            proto_err_reg <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_reg[o] <= state_next[o];
                owner_reg[o] <= owner_next[o];
                ptr_reg[o]   <= ptr_next[o];
            end
            proto_err_reg <= proto_err_reg | (|err_vec);
        end
    end

    assign proto_err_o = proto_err_reg;
endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus a random
// phase, each cycle's expectation queued from a reference model then compared.
module tb_switch_allocator;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  valid, head, tail;
    logic [24:0] dir;
    logic [14:0] credit;
    logic [14:0] sel_o;
    logic [4:0]  sel_valid_o, send_data_o, counter_minus_o, locked_o;
    logic        proto_err_o;

    switch_allocator dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (valid),
        .req_head_i      (head),
        .req_tail_i      (tail),
        .req_dir_i       (dir),
        .credit_all_i    (credit),
        .sel_o           (sel_o),
        .sel_valid_o     (sel_valid_o),
        .send_data_o     (send_data_o),
        .counter_minus_o (counter_minus_o),
        .locked_o        (locked_o),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] sel;
        logic [4:0]  sv;
        logic [4:0]  sd;
        logic [4:0]  cm;
        logic [4:0]  lk;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_cyc    = 0;

    bit m_lock[5], n_lock[5];
    int m_owner[5], n_owner[5];
    int m_ptr[5], n_ptr[5];
    bit m_err, n_err_flag;

    logic [4:0]  last_sd, last_sv, last_cm, last_lk;
    logic [14:0] last_sel;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_eval(output exp_t e);
        bit owns[5];
        int w;
        int c;
        e = '0;
        for (int o = 0; o < 5; o++) begin
            n_lock[o] = m_lock[o]; n_owner[o] = m_owner[o]; n_ptr[o] = m_ptr[o];
            owns[o] = 1'b0;
        end
        n_err_flag = m_err;
        if (rst) begin
            for (int o = 0; o < 5; o++) begin
                n_lock[o] = 1'b0; n_owner[o] = 0; n_ptr[o] = 0;
            end
            n_err_flag = 1'b0;
            return;
        end
        e.err = m_err;
        for (int o = 0; o < 5; o++)
            if (m_lock[o]) owns[m_owner[o]] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (valid[i]) begin
                if (head[i]) begin
                    if ($countones(dir[i*5 +: 5]) != 1 || owns[i]) n_err_flag = 1'b1;
                end else if (!owns[i]) begin
                    n_err_flag = 1'b1;
                end
            end
        end
        for (int o = 0; o < 5; o++) begin
            e.lk[o] = m_lock[o];
            w = -1;
            if (m_lock[o]) begin
                if (valid[m_owner[o]] && !head[m_owner[o]]) w = m_owner[o];
            end else begin
                for (int k = 1; k <= 5; k++) begin
                    c = (m_ptr[o] + k) % 5;
                    if (w < 0 && valid[c] && head[c] && dir[c*5 + o] && !owns[c] &&
                        $countones(dir[c*5 +: 5]) == 1)
                        w = c;
                end
            end
            if (w >= 0 && credit[o*3 +: 3] != 3'd0) begin
                e.sel[o*3 +: 3] = w[2:0];
                e.sv[o] = 1'b1;
                e.cm[o] = 1'b1;
                e.sd[w] = 1'b1;
                if (m_lock[o]) begin
                    if (tail[w]) n_lock[o] = 1'b0;
                end else begin
                    n_ptr[o] = w;
                    if (!tail[w]) begin
                        n_lock[o] = 1'b1;
                        n_owner[o] = w;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input string name);
        exp_t e, g;
        model_eval(e);
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        chk({name, ".sel"}, sel_o, g.sel);
        chk({name, ".sel_valid"}, sel_valid_o, g.sv);
        chk({name, ".send"}, send_data_o, g.sd);
        chk({name, ".cminus"}, counter_minus_o, g.cm);
        chk({name, ".locked"}, locked_o, g.lk);
        chk({name, ".err"}, proto_err_o, g.err);
        last_sel = sel_o; last_sv = sel_valid_o; last_sd = send_data_o;
        last_cm = counter_minus_o; last_lk = locked_o; last_err = proto_err_o;
        $display("cyc %0d %s: v=%b h=%b t=%b sel=%h sv=%b sd=%b cm=%b lk=%b err=%b",
                 n_cyc, name, valid, head, tail, sel_o, sel_valid_o, send_data_o,
                 counter_minus_o, locked_o, proto_err_o);
        n_cyc++;
        @(posedge clk);
        for (int o = 0; o < 5; o++) begin
            m_lock[o] = n_lock[o]; m_owner[o] = n_owner[o]; m_ptr[o] = n_ptr[o];
        end
        m_err = n_err_flag;
        #1;
    endtask

    task automatic clear_in();
        valid = '0; head = '0; tail = '0; dir = '0;
    endtask

    task automatic flit(input int i, input bit h, input bit t, input logic [4:0] d);
        valid[i] = 1'b1; head[i] = h; tail[i] = t; dir[i*5 +: 5] = d;
    endtask

    task automatic set_credit(input int o, input logic [2:0] c);
        credit[o*3 +: 3] = c;
    endtask

    logic [4:0] rr_exp [4];

    initial begin
        rr_exp[0] = 5'b00010; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b10000; rr_exp[3] = 5'b00010;
        for (int o = 0; o < 5; o++) begin
            m_lock[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0;
        end
        m_err = 1'b0;
        rst = 1'b1;
        clear_in();
        credit = {5{3'd7}};
        @(posedge clk); #1;

        flit(0, 1'b1, 1'b1, 5'b00001);
        cycle("reset");
        chk("reset.send_zero", last_sd, 5'b00000);
        clear_in();
        rst = 1'b0;

        set_credit(3, 3'd3);
        flit(0, 1'b1, 1'b1, 5'b01000);
        cycle("single");
        chk("single.send_local", last_sd, 5'b00001);
        chk("single.sv_east", last_sv, 5'b01000);
        chk("single.sel_east", last_sel, 15'd0);
        cycle("single_after");
        chk("single.unlocked", last_lk, 5'b00000);

        clear_in();
        set_credit(3, 3'd7);
        flit(4, 1'b1, 1'b1, 5'b00001);
        flit(2, 1'b1, 1'b1, 5'b00001);
        flit(1, 1'b1, 1'b1, 5'b00001);
        for (int k = 0; k < 4; k++) begin
            cycle("rr");
            chk("rr.order", last_sd, rr_exp[k]);
        end

        clear_in();
        flit(2, 1'b1, 1'b0, 5'b00010);
        cycle("wh_head");
        chk("wh_head.send", last_sd, 5'b00100);
        flit(2, 1'b0, 1'b0, 5'b00000);
        flit(4, 1'b1, 1'b1, 5'b00010);
        cycle("wh_body");
        chk("wh_body.send", last_sd, 5'b00100);
        chk("wh_body.locked", last_lk, 5'b00010);
        flit(2, 1'b0, 1'b1, 5'b00000);
        cycle("wh_tail");
        chk("wh_tail.send", last_sd, 5'b00100);
        clear_in();
        flit(4, 1'b1, 1'b1, 5'b00010);
        cycle("wh_north");
        chk("wh_north.send", last_sd, 5'b10000);
        chk("wh_north.sel", last_sel, 15'(4 << 3));

        clear_in();
        flit(4, 1'b1, 1'b0, 5'b01000);
        cycle("cs_head");
        flit(4, 1'b0, 1'b0, 5'b00000);
        set_credit(3, 3'd0);
        for (int k = 0; k < 2; k++) begin
            cycle("cs_stall");
            chk("cs_stall.send", last_sd, 5'b00000);
            chk("cs_stall.locked", last_lk, 5'b01000);
        end
        set_credit(3, 3'd1);
        cycle("cs_go");
        chk("cs_go.send", last_sd, 5'b10000);
        chk("cs_go.cminus", last_cm, 5'b01000);
        flit(4, 1'b0, 1'b1, 5'b00000);
        set_credit(3, 3'd7);
        cycle("cs_tail");

        clear_in();
        flit(2, 1'b1, 1'b0, 5'b10000);
        cycle("mp_head");
        flit(2, 1'b0, 1'b0, 5'b00000);
        rst = 1'b1;
        cycle("mp_rst");
        chk("mp_rst.locked", last_lk, 5'b00000);
        rst = 1'b0;
        cycle("mp_body");
        chk("mp_body.send", last_sd, 5'b00000);
        clear_in();
        cycle("mp_err");
        chk("mp_err.flag", last_err, 1'b1);

        rst = 1'b1;
        cycle("rst2");
        rst = 1'b0;
        flit(0, 1'b1, 1'b1, 5'b00110);
        cycle("bad_head");
        chk("bad_head.send", last_sd, 5'b00000);
        chk("bad_head.err_pending", last_err, 1'b0);
        clear_in();
        for (int k = 0; k < 3; k++) begin
            cycle("bad_hold");
            chk("bad_hold.err", last_err, 1'b1);
        end

        for (int k = 0; k < 80; k++) begin
            rst = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < 5; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                head[i]  = ($urandom_range(0, 2) == 0);
                tail[i]  = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 15) == 0)
                    dir[i*5 +: 5] = 5'($urandom_range(0, 31));
                else
                    dir[i*5 +: 5] = 5'(1 << $urandom_range(0, 4));
                credit[i*3 +: 3] = 3'($urandom_range(0, 7));
            end
            cycle("rand");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
